// File: rtl/clk_div_prog.sv
// Programmable 50%-duty clock divider. It divides clk by any N from 2 to 2^CNT_W-1
// and provides rise/fall tick strobes in the clk domain. Divisor changes take effect on period boundaries.
`timescale 1ns/1ps
module clk_div_prog #(
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_div,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic [CNT_W-1:0] div_cur,
  output logic             load_pend
);

  localparam logic [CNT_W-1:0] DIV_RST_V = CNT_W'(DIV_RST);
  localparam logic [CNT_W-1:0] DIV_MIN   = CNT_W'(2);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_cur;
  logic [CNT_W-1:0] r_div_pend;
  logic             r_load_pend;
  logic             r_pos_q;
  logic             r_neg_q;
  logic             r_even;
  logic             r_tick_rise;
  logic             r_tick_fall;

  logic [CNT_W-1:0] w_val_clamp;
  logic             w_boundary;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_half_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  state_t           w_state_nxt;
  logic             w_run_nxt;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    w_val_clamp = (div_val < DIV_MIN) ? DIV_MIN : div_val;
    w_boundary  = (r_state == IDLE) || (r_cnt == r_div_cur - CNT_W'(1));
    w_div_nxt   = r_div_cur;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_state_nxt = RUN;
    if (w_boundary) begin
      w_cnt_nxt   = '0;
      w_state_nxt = en ? RUN : IDLE;
      if (div_load)         w_div_nxt = w_val_clamp;
      else if (r_load_pend) w_div_nxt = r_div_pend;
    end
    w_run_nxt  = (w_state_nxt == RUN);
    w_half_nxt = (w_div_nxt >> 1) + CNT_W'(w_div_nxt[0]);
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so every flop
  // sees the values from before the edge, whatever order the statements appear in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_div_cur   <= DIV_RST_V;
      r_div_pend  <= DIV_RST_V;
      r_load_pend <= 1'b0;
      r_pos_q     <= 1'b0;
      r_even      <= ~DIV_RST_V[0];
      r_tick_rise <= 1'b0;
      r_tick_fall <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_div_cur   <= w_div_nxt;
      r_even      <= ~w_div_nxt[0];
      r_pos_q     <= w_run_nxt && (w_cnt_nxt < w_half_nxt);
      r_tick_rise <= w_run_nxt && (w_cnt_nxt == '0);
      r_tick_fall <= w_run_nxt && (w_cnt_nxt == w_half_nxt);
      if (w_boundary) begin
        r_load_pend <= 1'b0;
        r_div_pend  <= w_div_nxt;
      end else if (div_load) begin
        r_load_pend <= 1'b1;
        r_div_pend  <= w_val_clamp;
      end
    end
  end

  // Half-cycle-delayed copy of the high phase; it trims the odd-N pulse to N/2 cycles.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) r_neg_q <= 1'b0;
    else        r_neg_q <= r_pos_q;
  end

  // Even divisors bypass the negedge flop. r_even only changes while r_pos_q is low, so it cannot glitch the output.
  assign clk_div   = r_pos_q & (r_neg_q | r_even);
  assign tick_rise = r_tick_rise;
  assign tick_fall = r_tick_fall;
  assign div_cur   = r_div_cur;
  assign load_pend = r_load_pend;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog. A period-level model predicts every output on each half cycle,
// and directed steps pin pulse widths and strobes to hand-computed values.
`timescale 1ns/1ps
module tb_clk_div_prog;

  localparam int CNT_W   = 8;
  localparam int DIV_RST = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [CNT_W-1:0] div_val = '0;
  logic             div_load = 1'b0;
  logic             clk_div, tick_rise, tick_fall, load_pend;
  logic [CNT_W-1:0] div_cur;

  int n_checks = 0;
  int n_errors = 0;

  // Period-level model: k is the cycle index within the current period of length n.
  bit m_run = 0;
  int m_k   = 0;
  int m_n   = DIV_RST;
  int m_pend = DIV_RST;
  bit m_pv  = 0;

  clk_div_prog #(.CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_val(div_val), .div_load(div_load),
    .clk_div(clk_div), .tick_rise(tick_rise), .tick_fall(tick_fall),
    .div_cur(div_cur), .load_pend(load_pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  // The output is high for exactly n half-cycles per period, starting at half-cycle n%2.
  function automatic bit exp_div(input int h);
    return m_run && (h >= m_n % 2) && (h < m_n % 2 + m_n);
  endfunction

  always begin
    @(posedge clk);
    if (!rst_n) begin
      m_run = 0; m_k = 0; m_n = DIV_RST; m_pend = DIV_RST; m_pv = 0;
    end else if (!m_run || m_k == m_n - 1) begin
      m_n  = div_load ? clamp(int'(div_val)) : (m_pv ? m_pend : m_n);
      m_pv = 0;
      m_run = en;
      m_k  = 0;
    end else begin
      m_k++;
      if (div_load) begin
        m_pend = clamp(int'(div_val));
        m_pv   = 1;
      end
    end
    #1;
    if (rst_n) begin
      check("mdl_clk_div_h0", 32'(clk_div), 32'(exp_div(2 * m_k)));
      check("mdl_tick_rise", 32'(tick_rise), 32'(m_run && m_k == 0));
      check("mdl_tick_fall", 32'(tick_fall), 32'(m_run && m_k == (m_n + 1) / 2));
      check("mdl_div_cur", 32'(div_cur), 32'(m_n));
      check("mdl_load_pend", 32'(load_pend), 32'(m_pv));
    end
    @(negedge clk);
    #1;
    if (rst_n) check("mdl_clk_div_h1", 32'(clk_div), 32'(exp_div(2 * m_k + 1)));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_k(input int k);
    int lim = 600;
    step(1);
    while (!(m_run && m_k == k) && lim > 0) begin
      step(1);
      lim--;
    end
    if (lim == 0) check("wait_k_timeout", 32'(m_k), 32'(k));
  endtask

  task automatic wait_n(input int n);
    int lim = 600;
    step(1);
    while (!(m_run && m_n == n && m_k == 1) && lim > 0) begin
      step(1);
      lim--;
    end
    if (lim == 0) check("wait_n_timeout", 32'(m_n), 32'(n));
  endtask

  // Polls every half clock, offset from the edges, so measured widths are exact.
  task automatic wait_level(input logic v, output bit ok);
    int lim = 200;
    while (clk_div !== v && lim > 0) begin
      #5;
      lim--;
    end
    ok = (lim > 0);
    if (!ok) check("clk_div_level_timeout", 32'(clk_div), 32'(v));
  endtask

  task automatic measure(input string name, input int hi, input int lo);
    time t0, t1, t2;
    bit ok;
    wait_level(1'b0, ok);
    if (ok) wait_level(1'b1, ok);
    t0 = $time;
    if (ok) wait_level(1'b0, ok);
    t1 = $time;
    if (ok) wait_level(1'b1, ok);
    t2 = $time;
    if (ok) begin
      check({name, "_high_ns"}, 32'(t1 - t0), 32'(hi));
      check({name, "_low_ns"}, 32'(t2 - t1), 32'(lo));
    end
  endtask

  initial begin
    // Reset values.
    #12;
    check("rst_clk_div", 32'(clk_div), 32'd0);
    check("rst_tick_rise", 32'(tick_rise), 32'd0);
    check("rst_tick_fall", 32'(tick_fall), 32'd0);
    check("rst_div_cur", 32'(div_cur), 32'd6);
    check("rst_load_pend", 32'(load_pend), 32'd0);
    step(1);
    rst_n = 1'b1;

    // N=6 start: tick and even-N rise right after the sampling edge.
    en = 1'b1;
    step(1);
    check("start_tick_rise", 32'(tick_rise), 32'd1);
    check("start_clk_div", 32'(clk_div), 32'd1);
    check("start_div_cur", 32'(div_cur), 32'd6);
    measure("n6", 30, 30);

    // N=5: 2.5 cycles high, 2.5 low.
    wait_k(2);
    div_val = 8'd5; div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    check("n5_load_pend", 32'(load_pend), 32'd1);
    wait_n(5);
    measure("n5", 25, 25);

    // Back to 6, then 6 -> 3 loaded at cnt=1.
    wait_k(1);
    div_val = 8'd6; div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    wait_n(6);
    wait_k(1);
    div_val = 8'd3; div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    check("n3_pend_set", 32'(load_pend), 32'd1);
    wait_k(5);
    check("n3_pend_at_cnt5", 32'(load_pend), 32'd1);
    check("n3_div_cur_old", 32'(div_cur), 32'd6);
    step(1);
    check("n3_pend_clear", 32'(load_pend), 32'd0);
    check("n3_div_cur_new", 32'(div_cur), 32'd3);
    check("n3_tick_rise", 32'(tick_rise), 32'd1);
    wait_n(3);
    measure("n3", 15, 15);

    // Coincident load of 0 at cnt=N-1: clamps to 2, never pending.
    wait_k(2);
    div_val = 8'd0; div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    check("clamp_load_pend", 32'(load_pend), 32'd0);
    check("clamp_div_cur", 32'(div_cur), 32'd2);
    wait_n(2);
    measure("n2", 10, 10);

    // Back to 6 coincidentally, then drop en at cnt=2.
    wait_k(1);
    div_val = 8'd6; div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    check("coinc6_div_cur", 32'(div_cur), 32'd6);
    wait_k(2);
    en = 1'b0;
    step(3);
    check("stop_last_cycle_fall_low", 32'(clk_div), 32'd0);
    step(1);
    check("stop_clk_div", 32'(clk_div), 32'd0);
    check("stop_tick_rise", 32'(tick_rise), 32'd0);
    check("stop_tick_fall", 32'(tick_fall), 32'd0);
    step(2);
    check("idle_tick_rise", 32'(tick_rise), 32'd0);
    en = 1'b1;
    step(1);
    check("restart_tick_rise", 32'(tick_rise), 32'd1);
    check("restart_clk_div", 32'(clk_div), 32'd1);

    // Reset while clk_div is high with a pending load.
    wait_k(1);
    div_val = 8'd4; div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    check("mid_pend", 32'(load_pend), 32'd1);
    check("mid_clk_div_high", 32'(clk_div), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_clk_div", 32'(clk_div), 32'd0);
    check("arst_tick_rise", 32'(tick_rise), 32'd0);
    check("arst_tick_fall", 32'(tick_fall), 32'd0);
    check("arst_div_cur", 32'(div_cur), 32'd6);
    check("arst_load_pend", 32'(load_pend), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(9);
    check("post_rst_div_cur", 32'(div_cur), 32'd6);
    check("post_rst_load_pend", 32'(load_pend), 32'd0);
    measure("post_rst_n6", 30, 30);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
